// File: rtl/dcache_controller.sv
// Blocking write-back controller for a 2-way data-cache SRAM: same-cycle hits,
// stall-and-replay on misses with dirty-victim writeback and line refill.
module dcache_controller #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 23,
    parameter int unsigned LINE_W  = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_write_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic [INDEX_W-1:0]  sram_addr_o,
    output logic [TAG_W+1:0]    sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    input  logic [TAG_W+1:0]    sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [31:0]         mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic                mem_ack_i,
    input  logic [LINE_W-1:0]   mem_data_i
);

    localparam int unsigned OFF_W  = 32 - TAG_W - INDEX_W;
    localparam int unsigned WSEL_W = $clog2(LINE_W / 32);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        FILL
    } state_t;

    state_t              state_q;
    logic [LINE_W-1:0]   refill_q;

    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  cpu_index;
    logic [WSEL_W-1:0]   cpu_word;
    logic [31:0]         cpu_line_addr;
    logic                victim_dirty;
    logic                unused_addr_bits;

    assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
    assign cpu_index        = cpu_addr_i[OFF_W +: INDEX_W];
    assign cpu_word         = cpu_addr_i[2 +: WSEL_W];
    assign cpu_line_addr    = {cpu_tag, cpu_index, {OFF_W{1'b0}}};
    assign victim_dirty     = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Sequencer and memory-side request registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            refill_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_i && !sram_hit_i) state_q <= MISS;
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_dirty) begin
                        state_q     <= WRITEBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {sram_tag_i[TAG_W-1:0], cpu_index, {OFF_W{1'b0}}};
                        mem_data_o  <= sram_data_i;
                    end else begin
                        state_q     <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= cpu_line_addr;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= cpu_line_addr;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_q      <= FILL;
                        refill_q     <= mem_data_i;
                        mem_enable_o <= 1'b0;
                    end
                end
                FILL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // CPU and SRAM side: hits are served in the probe cycle itself
    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = cpu_index;
        sram_tag_o    = {2'b00, cpu_tag};
        sram_data_o   = sram_data_i;
        case (state_q)
            IDLE: begin
                sram_enable_o = cpu_req_i;
                if (cpu_req_i) begin
                    if (!sram_hit_i) begin
                        cpu_stall_o = 1'b1;
                    end else if (cpu_write_i) begin
                        sram_write_o = 1'b1;
                        sram_tag_o   = {2'b11, cpu_tag};
                        sram_data_o[{cpu_word, 5'b00000} +: 32] = cpu_data_i;
                    end else begin
                        cpu_data_o = sram_data_i[{cpu_word, 5'b00000} +: 32];
                    end
                end
            end
            MISS: begin
                cpu_stall_o   = 1'b1;
                sram_enable_o = 1'b1;
            end
            WRITEBACK, REFILL: cpu_stall_o = 1'b1;
            FILL: begin
                cpu_stall_o   = 1'b1;
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_tag_o    = {2'b10, cpu_tag};
                sram_data_o   = refill_q;
            end
            default: cpu_stall_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural SRAM and memory, abstract LRU cache
// reference with a flat golden memory, and a scoreboard monitor on completions.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Backing memory and golden (architecturally visible) memory, line granular
    logic [255:0] mem_q  [logic [26:0]];
    logic [255:0] gold_q [logic [26:0]];

    function automatic logic [255:0] pat_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {la, 3'(w), 2'b01};
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [26:0] la);
        return mem_q.exists(la) ? mem_q[la] : pat_line(la);
    endfunction

    function automatic logic [255:0] gold_line(input logic [26:0] la);
        return gold_q.exists(la) ? gold_q[la] : pat_line(la);
    endfunction

    // Behavioural 2-way SRAM; lookup compares against the CPU address tag
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic         s_h0, s_h1, s_way;

    initial for (int i = 0; i < 16; i++) begin
        s_data[i][0] = '0;
        s_data[i][1] = '0;
    end

    always_comb begin
        s_h0 = s_tag[sram_addr_o][0][24] && (s_tag[sram_addr_o][0][22:0] == cpu_addr_i[31:9]);
        s_h1 = s_tag[sram_addr_o][1][24] && (s_tag[sram_addr_o][1][22:0] == cpu_addr_i[31:9]);
        s_way = s_h0 ? 1'b0 : (s_h1 ? 1'b1 : s_lru[sram_addr_o]);
        sram_hit_i  = sram_enable_o && (s_h0 || s_h1);
        sram_tag_i  = s_tag[sram_addr_o][s_way];
        sram_data_i = s_data[sram_addr_o][s_way];
    end

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 16; i++) begin
                s_tag[i][0] <= '0;
                s_tag[i][1] <= '0;
                s_lru[i]    <= 1'b0;
            end
        end else if (sram_enable_o && (sram_hit_i || sram_write_o)) begin
            s_lru[sram_addr_o] <= ~s_way;
            if (sram_write_o) begin
                s_tag[sram_addr_o][s_way]  <= sram_tag_o;
                s_data[sram_addr_o][s_way] <= sram_data_o;
            end
        end
    end

    // Abstract cache reference: per set, slot 0 = most recently used
    typedef struct {
        logic         write;
        logic [31:0]  addr;
        logic [255:0] line_after;
        logic [255:0] fill_line;
        bit           miss;
        bit           dirty;
        logic [31:0]  wb_addr;
        logic [31:0]  rd_addr;
    } exp_t;

    exp_t        sb[$];
    logic [22:0] ref_tag   [16][2];
    bit          ref_dirty [16][2];
    int          ref_cnt   [16];

    task automatic clear_model();
        for (int i = 0; i < 16; i++) ref_cnt[i] = 0;
        gold_q = mem_q;
    endtask

    task automatic ref_access(input logic [31:0] a, input logic w, input logic [31:0] d, output exp_t e);
        int           idx;
        int           pos;
        bit           dd;
        logic [22:0]  tg;
        logic [26:0]  la;
        logic [255:0] l;
        idx = int'(a[8:5]);
        tg  = a[31:9];
        la  = a[31:5];
        pos = -1;
        e.write = w; e.addr = a; e.rd_addr = {la, 5'b0};
        e.miss = 0; e.dirty = 0; e.wb_addr = '0;
        l = gold_line(la);
        e.fill_line = l;
        for (int i = 0; i < ref_cnt[idx]; i++) if (ref_tag[idx][i] == tg) pos = i;
        if (pos >= 0) begin
            dd = ref_dirty[idx][pos];
            if (pos == 1) begin
                ref_tag[idx][1]   = ref_tag[idx][0];
                ref_dirty[idx][1] = ref_dirty[idx][0];
            end
            ref_tag[idx][0]   = tg;
            ref_dirty[idx][0] = dd | w;
        end else begin
            e.miss = 1;
            if (ref_cnt[idx] == 2) begin
                e.dirty   = ref_dirty[idx][1];
                e.wb_addr = {ref_tag[idx][1], a[8:5], 5'b0};
            end else begin
                ref_cnt[idx]++;
            end
            ref_tag[idx][1]   = ref_tag[idx][0];
            ref_dirty[idx][1] = ref_dirty[idx][0];
            ref_tag[idx][0]   = tg;
            ref_dirty[idx][0] = w;
        end
        if (w) l[int'(a[4:2])*32 +: 32] = d;
        gold_q[la]   = l;
        e.line_after = l;
    endtask

    // Memory responder: ack after a configurable delay, checks request hold
    int           wb_delay_cfg = -1;
    int           rd_delay_cfg = -1;
    bit           r_wb_seen, r_rd_seen;
    logic [31:0]  r_wb_addr, r_rd_addr;
    int           r_wb_d, r_rd_d;
    logic [31:0]  rs_a;
    logic         rs_w;
    logic [255:0] rs_wd;
    int           rs_d, rs_cfg;
    bit           rs_ok, rs_abort;

    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            while (rst_i && mem_enable_o) begin
                rs_a = mem_addr_o; rs_w = mem_write_o; rs_wd = mem_data_o;
                rs_cfg = rs_w ? wb_delay_cfg : rd_delay_cfg;
                rs_d = (rs_cfg >= 0) ? rs_cfg : int'($urandom_range(1, 6));
                if (rs_w) begin
                    r_wb_seen = 1; r_wb_addr = rs_a; r_wb_d = rs_d;
                end else begin
                    r_rd_seen = 1; r_rd_addr = rs_a; r_rd_d = rs_d;
                end
                rs_ok = 1; rs_abort = 0;
                for (int i = 0; i < rs_d; i++) begin
                    @(posedge clk_i); #1;
                    if (!rst_i) begin
                        rs_abort = 1;
                        break;
                    end
                    if (mem_enable_o !== 1'b1 || mem_addr_o !== rs_a || mem_write_o !== rs_w ||
                        (rs_w && mem_data_o !== rs_wd) || cpu_stall_o !== 1'b1) rs_ok = 0;
                end
                if (!rs_abort) begin
                    chk("mem_hold", 256'(rs_ok), 256'(1));
                    mem_ack_i  = 1'b1;
                    mem_data_i = rs_w ? '0 : mem_line(rs_a[31:5]);
                    if (rs_w) mem_q[rs_a[31:5]] = rs_wd;
                    @(posedge clk_i); #1;
                    mem_ack_i = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: checks fills during stalls and each completed access
    int          stall_cnt = 0;
    int          done_cnt  = 0;
    int          last_stall = 0;
    logic [31:0] last_wb_addr = '0;
    exp_t        me;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            stall_cnt = 0; r_wb_seen = 0; r_rd_seen = 0;
        end else if (cpu_req_i) begin
            if (cpu_stall_o) begin
                stall_cnt++;
                if (sram_write_o && sb.size() > 0) begin
                    chk("fill_tag", 256'(sram_tag_o), 256'({2'b10, sb[0].addr[31:9]}));
                    chk("fill_data", sram_data_o, sb[0].fill_line);
                end
            end else begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 256'(1), 256'(0));
                end else begin
                    me = sb.pop_front();
                    if (me.write) begin
                        chk("store_we", 256'(sram_write_o), 256'(1));
                        chk("store_tag", 256'(sram_tag_o), 256'({2'b11, me.addr[31:9]}));
                        chk("store_line", sram_data_o, me.line_after);
                    end else begin
                        chk("load_data", 256'(cpu_data_o), 256'(me.line_after[int'(me.addr[4:2])*32 +: 32]));
                        chk("load_we", 256'(sram_write_o), 256'(0));
                    end
                    if (me.miss) begin
                        chk("stall_cycles", 256'(stall_cnt), 256'(4 + r_rd_d + (me.dirty ? r_wb_d + 1 : 0)));
                        chk("rd_addr", 256'(r_rd_seen ? r_rd_addr : 32'hFFFF_FFFF), 256'(me.rd_addr));
                        chk("wb_seen", 256'(r_wb_seen), 256'(me.dirty));
                        if (me.dirty) chk("wb_addr", 256'(r_wb_addr), 256'(me.wb_addr));
                    end else begin
                        chk("hit_stall", 256'(stall_cnt), 256'(0));
                        chk("hit_no_mem", 256'(r_wb_seen | r_rd_seen), 256'(0));
                    end
                    last_stall   = stall_cnt;
                    last_wb_addr = r_wb_seen ? r_wb_addr : 32'h0;
                end
                stall_cnt = 0; r_wb_seen = 0; r_rd_seen = 0;
                done_cnt++;
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        int   start;
        ref_access(a, w, d, e);
        sb.push_back(e);
        cpu_req_i = 1'b1; cpu_write_i = w; cpu_addr_i = a; cpu_data_i = d;
        start = done_cnt;
        for (int i = 0; i < 200 && done_cnt == start; i++) begin
            @(posedge clk_i); #1;
        end
        if (done_cnt == start) chk("access_timeout", 256'(0), 256'(1));
        cpu_req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        cpu_req_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("idle_data", 256'(cpu_data_o), 256'(0));
            chk("idle_sram_en", 256'(sram_enable_o), 256'(0));
            chk("idle_stall", 256'(cpu_stall_o), 256'(0));
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        logic [255:0] l;
        int           n;
        rst_i = 1'b0; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_sram_en", 256'(sram_enable_o), 256'(0));
        chk("rst_sram_we", 256'(sram_write_o), 256'(0));
        chk("rst_cpu_data", 256'(cpu_data_o), 256'(0));
        l = pat_line(27'd2);
        l[31:0] = 32'h1111_1111;
        mem_q[27'd2] = l;
        clear_model();
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        rd_delay_cfg = 5;
        access(32'h0000_0040, 1'b0, 32'h0);
        chk("cold_stall", 256'(last_stall), 256'(9));
        rd_delay_cfg = -1;
        access(32'h0000_0044, 1'b0, 32'h0);
        access(32'h0000_0048, 1'b1, 32'hDEAD_BEEF);

        access(32'h0000_0240, 1'b0, 32'h0);
        access(32'h0000_0244, 1'b1, $urandom);
        access(32'h0000_0440, 1'b0, 32'h0);
        access(32'h0000_0640, 1'b0, 32'h0);
        chk("victim_wb_addr", 256'(last_wb_addr), 256'(32'h0000_0240));
        access(32'h0000_0648, 1'b0, 32'h0);

        access(32'h0000_0260, 1'b1, $urandom);
        access(32'h0000_0460, 1'b0, 32'h0);
        wb_delay_cfg = 20;
        access(32'h0000_0660, 1'b0, 32'h0);
        wb_delay_cfg = -1;
        idle(2);

        // Reset while the refill read is outstanding
        rd_delay_cfg = 30;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0880;
        n = 0;
        while (!(mem_enable_o && !mem_write_o) && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("reach_refill", 256'(mem_enable_o && !mem_write_o), 256'(1));
        @(negedge clk_i);
        rst_i = 1'b0; cpu_req_i = 1'b0;
        #1;
        chk("midrst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("midrst_stall", 256'(cpu_stall_o), 256'(0));
        chk("midrst_sram_en", 256'(sram_enable_o), 256'(0));
        sb.delete();
        clear_model();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        rd_delay_cfg = -1;
        @(posedge clk_i); #1;
        access(32'h0000_0880, 1'b0, 32'h0);
        chk("post_reset_miss", 256'(last_stall > 0), 256'(1));

        for (int i = 0; i < 150; i++) begin
            access({23'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom), 2'b00},
                   1'($urandom), $urandom);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Controller sitting directly upstream of the 2-way data-cache SRAM (16 sets, 32-byte lines, 25-bit stored tag).
- Accepts 32-bit word loads and stores from the MEM pipeline stage.
- Probes the SRAM and returns hit data with no stall. On a miss it stalls the CPU, writes back a dirty victim, refills from data memory over a request/ack handshake, then replays the access.

Parameters:
- INDEX_W, 4, set-index width (16 sets).
- TAG_W, 23, address tag width. Stored SRAM tag is {valid, dirty, tag} = 25 bits.
- LINE_W, 256, cache line width in bits (32 bytes).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low (0 = reset).
- cpu_req_i  input  1  CPU access request (MEM-stage load or store).
- cpu_write_i  input  1  1 = store, 0 = load.
- cpu_addr_i  input  32  byte address: [31:9] tag, [8:5] index, [4:2] word, [1:0] ignored.
- cpu_data_i  input  32  store data.
- cpu_data_o  output  32  load data.
- cpu_stall_o  output  1  stall the pipeline.
- sram_addr_o  output  4  SRAM set index.
- sram_tag_o  output  25  {valid, dirty, tag} to SRAM.
- sram_data_o  output  256  line written to SRAM.
- sram_enable_o  output  1  SRAM access enable.
- sram_write_o  output  1  SRAM write strobe.
- sram_tag_i  input  25  SRAM tag out: hit way's tag on hit, LRU victim's tag on miss.
- sram_data_i  input  256  SRAM data out: hit way on hit, LRU victim on miss.
- sram_hit_i  input  1  SRAM combinational hit.
- mem_enable_o  output  1  memory request, level held until ack.
- mem_write_o  output  1  1 = line write, 0 = line read.
- mem_addr_o  output  32  line-aligned memory address (bits [4:0] = 0).
- mem_data_o  output  256  writeback line.
- mem_ack_i  input  1  one-cycle memory completion pulse. On reads, mem_data_i is valid in the same cycle.
- mem_data_i  input  256  refill line.

Behaviour:
- Reset (rst_i = 0, asynchronous): state = IDLE; mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, refill buffer = 0. With no request, cpu_stall_o = 0, sram_enable_o = 0, sram_write_o = 0, cpu_data_o = 0.
- States: IDLE, MISS, WRITEBACK, REFILL, FILL.
- IDLE:
  - sram_enable_o = cpu_req_i; sram_addr_o = cpu_addr_i[8:5].
  - Load hit: cpu_data_o = word cpu_addr_i[4:2] of sram_data_i (word 0 = bits [31:0]), combinational. cpu_stall_o = 0.
  - Store hit: same cycle, sram_write_o = 1; sram_data_o = sram_data_i with the selected word replaced by cpu_data_i; sram_tag_o = {1, 1, addr tag}; cpu_stall_o = 0.
  - Miss (cpu_req_i & ~sram_hit_i): cpu_stall_o = 1 combinationally; no SRAM write; next state = MISS.
- MISS (one cycle), stall = 1:
  - If sram_tag_i[24] & sram_tag_i[23] (valid and dirty): next state = WRITEBACK; register mem_write_o = 1, mem_addr_o = {sram_tag_i[22:0], index, 5'b0}, mem_data_o = sram_data_i.
  - Otherwise: next state = REFILL; register mem_write_o = 0, mem_addr_o = {cpu tag, index, 5'b0}.
  - mem_enable_o = 1 from the next cycle.
- WRITEBACK: mem_* held stable until mem_ack_i. On ack: next state = REFILL; read request for the CPU line issued the following cycle (mem_write_o = 0, new address); mem_enable_o stays 1.
- REFILL: on mem_ack_i, latch mem_data_i into the refill buffer; mem_enable_o = 0 next cycle; next state = FILL.
- FILL (one cycle): sram_enable_o = 1, sram_write_o = 1, sram_tag_o = {1, 0, cpu tag}, sram_data_o = refill buffer; next state = IDLE.
- Replay: after FILL, IDLE re-probes and hits. A store miss completes as a store hit on replay, which sets dirty. cpu_stall_o drops in the replay cycle.
- Stall latency:
  - Clean miss: 4 + (ack delay) stall cycles.
  - Dirty miss: adds the writeback ack wait.
- cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i are held stable by the CPU while cpu_stall_o = 1. Changes during a stall are unsupported.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- Reset mid-transaction: immediate return to IDLE with mem_enable_o = 0. The SRAM is reset by the same reset.
- cpu_req_i = 0 in IDLE: no SRAM enable; cpu_data_o = 0.

Test Plan:
- Cold load, addr 0x0000_0040, mem acks 5 cycles after request with word 0 = 0x1111_1111 → mem read at 0x40; FILL tag = {1, 0, 0}; replay returns 0x1111_1111; stall = 9 cycles.
- Repeat load of 0x0000_0044 → hit, cpu_stall_o = 0, word 1 of the line returned the same cycle, no mem_enable_o.
- Store hit 0x0000_0048, data 0xDEAD_BEEF → same-cycle SRAM write; word 2 = 0xDEAD_BEEF; stored tag dirty bit = 1; other words unchanged.
- Set 2 filled with tags 0x1 (dirty, LRU) and 0x2; load tag 0x3 at set 2 → mem write at {0x1, 2, 0} = 0x0000_0240 with the victim line, then read at 0x0000_0640; replay hits.
- rst_i driven low while in REFILL → mem_enable_o = 0 and state IDLE in the same cycle; a later request for the same line misses again.
- Ack delayed 20 cycles in WRITEBACK → mem_addr_o, mem_data_o, mem_write_o and mem_enable_o stable for all 20 cycles; cpu_stall_o = 1 throughout.
